// File: rtl/cpu_types_pkg.sv
// Shared CPU types and instruction-cache constants (word type, frame/address layouts, FSM states).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icache_addr_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame storage: combinational read, single write port,
// valid bits cleared synchronously while nRST is low.
module icache_array
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [$clog2(SETS)-1:0]    rd_idx,
    output logic                       rd_valid,
    output logic [30-$clog2(SETS)-1:0] rd_tag,
    output word_t                      rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(SETS)-1:0]    wr_idx,
    input  logic [30-$clog2(SETS)-1:0] wr_tag,
    input  word_t                      wr_data
);

    localparam int TAG_W = 30 - $clog2(SETS);

    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem  [SETS];
    word_t            data_mem [SETS];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    // Tag/data contents are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-word fills.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload,
    output word_t hit_count,
    output word_t miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t state_reg;
    word_t         miss_addr_reg;
    logic          iren_reg;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;
    logic             match;
    logic             miss;
    logic             fill_done;
    logic [1:0]       unused_bytoff;

    // Byte offset within the word never affects which instruction is returned.
    assign unused_bytoff = imemaddr[1:0];

    icache_array #(
        .SETS(SETS)
    ) u_array (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (imemaddr[IDX_W+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_done),
        .wr_idx   (miss_addr_reg[IDX_W+1:2]),
        .wr_tag   (miss_addr_reg[31:IDX_W+2]),
        .wr_data  (iload)
    );

    assign match     = rd_valid && (rd_tag == imemaddr[31:IDX_W+2]);
    assign miss      = (state_reg == IDLE) && imemREN && !match;
    assign fill_done = (state_reg == FILL) && !iwait;

    always_comb begin
        ihit     = (state_reg == IDLE) && imemREN && match;
        imemload = ihit ? rd_data : '0;
    end

    // While filling, the request inputs are ignored; only miss_addr_reg drives the fill.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
            iren_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss) begin
                        miss_addr_reg <= {imemaddr[31:2], 2'b00};
                        iren_reg      <= 1'b1;
                        state_reg     <= FILL;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        iren_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    iren_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign iREN  = iren_reg;
    assign iaddr = miss_addr_reg;

`ifdef ICACHE_STATS_EN
    word_t hit_count_reg;
    word_t miss_count_reg;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (ihit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
